dcache_responder: RTL and testbench
===================================

// Module: dcache_responder
// PURPOSE
//   Responder side of the pipeline's data-memory port: accepts MEM-stage load/store requests and answers from a
//   direct-mapped, write-back, write-allocate cache. Misses are served from a slow backing memory over an
//   enable/ack handshake. While a miss is in service, cpu_stall_o freezes the pipeline.
//   Sits between EX/MEM outputs (addr, write data, MemRd/MemWr) and the off-chip data memory.
// PARAMETERS
//   NUM_LINES   32   cache lines (power of 2); index = addr[4+log2(NUM_LINES):5]
//   LINE_BITS   256  line size in bits (8 words); word offset = addr[4:2]
//   ADDR_W      32   byte address width; tag = addr[ADDR_W-1:5+log2(NUM_LINES)] (22 b at defaults)
// PORTS
//   clk_i         in   1          clock, rising edge
//   rst_i         in   1          asynchronous reset, active-low
//   cpu_addr_i    in   ADDR_W     byte address from EX/MEM; bits [1:0] ignored
//   cpu_wdata_i   in   32         store data
//   cpu_memrd_i   in   1          load request
//   cpu_memwr_i   in   1          store request
//   cpu_rdata_o   out  32         load data; valid when cpu_memrd_i=1 and cpu_stall_o=0
//   cpu_stall_o   out  1          1 = request not yet served; pipeline must hold all request inputs stable
//   mem_enable_o  out  1          backing-memory request valid
//   mem_write_o   out  1          1 = line write-back, 0 = line fetch
//   mem_addr_o    out  ADDR_W     line-aligned address (bits [4:0]=0)
//   mem_wdata_o   out  LINE_BITS  victim line for write-back
//   mem_rdata_i   in   LINE_BITS  fetched line; valid in the cycle of mem_ack_i
//   mem_ack_i     in   1          one-cycle pulse: current memory request complete
// BEHAVIOUR
//   Reset (rst_i=0, async): state=IDLE; all valid and dirty bits = 0; mem_enable_o=0, mem_write_o=0,
//     mem_addr_o=0, mem_wdata_o=0; cpu_stall_o=0; cpu_rdata_o=0. Data array contents are not cleared.
//     Reset during WRITEBACK/ALLOCATE abandons the memory transaction; a late ack is ignored in IDLE.
//   req = cpu_memrd_i | cpu_memwr_i. Both asserted is treated as a store.
//   hit = valid[idx] & (tag[idx]==addr tag).
//   Outputs cpu_stall_o, cpu_rdata_o, and mem_* are combinational from state and arrays.
//   FSM:
//     IDLE
//       - no req: stall=0; no state change.
//       - req & hit: stall=0 in the same cycle (0 added latency).
//         - Load: cpu_rdata_o = word addr[4:2] of the line.
//         - Store: at the clock edge, merge the word into the line and set dirty[idx]=1.
//       - req & miss: stall=1 in the same cycle.
//         - Next state WRITEBACK if valid&dirty at idx, else ALLOCATE.
//     WRITEBACK
//       - stall=1; mem_enable=1, mem_write=1, mem_addr={victim tag, idx, 5'b0}, mem_wdata=victim line.
//       - Held stable until mem_ack_i, then ALLOCATE.
//     ALLOCATE
//       - stall=1; mem_enable=1, mem_write=0, mem_addr={req tag, idx, 5'b0}.
//       - On mem_ack_i: write mem_rdata_i into the line, tag=req tag, valid=1, dirty=0; next state IDLE.
//     Back in IDLE, the held request now hits and is served normally (stall drops that cycle).
//   Latency:
//     - Clean miss = 1 + N + 1 cycles of stall, where N = cycles from enable to ack inclusive.
//     - Dirty miss adds N_wb.
//   Ack outside WRITEBACK/ALLOCATE: ignored. mem_enable_o drops the cycle after ack, or stays high into the
//     next phase (WRITEBACK->ALLOCATE) with the new address and mem_write_o.
//   Store miss: write-allocate; the word is merged on the IDLE hit cycle after the refill, never into memory directly.
//   Index wrap: index uses low bits only; same-index different-tag accesses evict (conflict miss each time).
//   Request change while stall=1: protocol violation; behaviour undefined (bench asserts on it).
// STRUCTURE
//   dcache_pkg: state encoding (IDLE, WRITEBACK, ALLOCATE); OFFSET_W=5, IDX_W, TAG_W localparams; tag/index
//     extract functions.
//   Sub-module dcache_sram: valid/dirty/tag and data arrays; one combinational read port and one
//     synchronous write port (full line + tag/valid/dirty).
//   dcache_responder holds the FSM, hit logic, word merge/select, and memory interface muxing.
// TESTING
//   1 Reset, then load 0x0000_0040 (cold): stall=1 -> ALLOCATE, mem_addr=0x40, write=0; ack after 10 cycles
//     with line word0=0xDEAD_BEEF -> stall drops next cycle, rdata=0xDEADBEEF; a repeat load has stall=0 with no mem request.
//   2 Store 0x1234_5678 to 0x44 (hit) -> no stall; load 0x44 -> 0x12345678; dirty[2]=1.
//   3 Load 0x0000_0440 (same idx 2, new tag) -> WRITEBACK first: mem_addr=0x40, write=1, wdata word1=0x12345678;
//     then ALLOCATE 0x440; total stall = 1+N_wb+N+1.
//   4 Store miss to clean line 0x80: ALLOCATE then merge; later evict -> write-back line contains stored word.
//   5 Assert rst_i=0 mid-ALLOCATE, then ack arrives after release -> FSM stays IDLE, mem_enable=0, old 0x40 now misses.
//   6 Random load/store stream vs. flat reference memory model with random ack delay 1-20 -> all load data matches.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg
//   Shared definitions for the data-cache responder: cache geometry,
//   FSM state encoding and address field extraction helpers.
//   Geometry: 32 lines of 256 bits (8 x 32-bit words), 32-bit byte addresses.
//   Address split: tag = addr[31:10], index = addr[9:5], word = addr[4:2].
package dcache_pkg;

   localparam int NUM_LINES = 32;
   localparam int LINE_BITS = 256;
   localparam int ADDR_W    = 32;
   localparam int OFFSET_W  = 5;
   localparam int IDX_W     = $clog2(NUM_LINES);
   localparam int TAG_W     = ADDR_W - OFFSET_W - IDX_W;
   localparam int WORDS     = LINE_BITS / 32;
   localparam int WORD_W    = $clog2(WORDS);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_ALLOCATE  = 2'd2
   } state_e;

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W +: IDX_W];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram
//   Storage for the direct-mapped cache: per-line valid/dirty flags, tag
//   array and line data array.
//   Ports:
//     clk_i, rst_i        clock / asynchronous active-low reset (clears flags only)
//     rd_idx_i            combinational read index
//     rd_valid_o, rd_dirty_o, rd_tag_o, rd_line_o   read port outputs
//     wr_en_i, wr_idx_i   synchronous write of a whole entry
//     wr_line_i, wr_tag_i, wr_valid_i, wr_dirty_i   write data
module dcache_sram
   import dcache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_W-1:0]     rd_idx_i,
   output logic                 rd_valid_o,
   output logic                 rd_dirty_o,
   output logic [TAG_W-1:0]     rd_tag_o,
   output logic [LINE_BITS-1:0] rd_line_o,
   input  logic                 wr_en_i,
   input  logic [IDX_W-1:0]     wr_idx_i,
   input  logic [LINE_BITS-1:0] wr_line_i,
   input  logic [TAG_W-1:0]     wr_tag_i,
   input  logic                 wr_valid_i,
   input  logic                 wr_dirty_i
);

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [NUM_LINES-1:0] dirty_q, dirty_d;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_BITS-1:0] data_q [NUM_LINES];

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (wr_en_i) begin
         valid_d[wr_idx_i] = wr_valid_i;
         dirty_d[wr_idx_i] = wr_dirty_i;
      end
   end

   // Only the flags are reset; a cleared valid bit makes tag/data don't-care.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_line_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder
//   Direct-mapped, write-back, write-allocate data cache answering MEM-stage
//   loads/stores. Misses write back a dirty victim, then fetch the line from
//   backing memory; the held request is then served as a hit.
//   Ports:
//     clk_i, rst_i                 clock / asynchronous active-low reset
//     cpu_addr_i, cpu_wdata_i      request address / store data
//     cpu_memrd_i, cpu_memwr_i     load / store request (both = store)
//     cpu_rdata_o, cpu_stall_o     load data / pipeline hold
//     mem_enable_o, mem_write_o    backing memory request / write-back select
//     mem_addr_o, mem_wdata_o      line address / victim line
//     mem_rdata_i, mem_ack_i       fetched line / completion pulse
module dcache_responder
   import dcache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [31:0]          cpu_wdata_i,
   input  logic                 cpu_memrd_i,
   input  logic                 cpu_memwr_i,
   output logic [31:0]          cpu_rdata_o,
   output logic                 cpu_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_BITS-1:0] mem_wdata_o,
   input  logic [LINE_BITS-1:0] mem_rdata_i,
   input  logic                 mem_ack_i
);

   state_e state_q, state_d;

   logic [IDX_W-1:0]     req_idx;
   logic [TAG_W-1:0]     req_tag;
   logic [WORD_W-1:0]    word_sel;
   logic                 req, hit;
   logic                 rd_valid, rd_dirty;
   logic [TAG_W-1:0]     rd_tag;
   logic [LINE_BITS-1:0] rd_line;
   logic [31:0]          line_words [WORDS];
   logic [LINE_BITS-1:0] merged_line;
   logic                 wr_en;
   logic [LINE_BITS-1:0] wr_line;
   logic                 unused_addr_bits;

   assign req_idx          = addr_idx(cpu_addr_i);
   assign req_tag          = addr_tag(cpu_addr_i);
   assign word_sel         = cpu_addr_i[2 +: WORD_W];
   assign unused_addr_bits = ^cpu_addr_i[1:0];
   assign req              = cpu_memrd_i | cpu_memwr_i;
   assign hit              = rd_valid & (rd_tag == req_tag);

   // Split the indexed line into words and build the store-merged line.
   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_words
         assign line_words[gi] = rd_line[gi*32 +: 32];
         assign merged_line[gi*32 +: 32] =
            (word_sel == WORD_W'(gi)) ? cpu_wdata_i : rd_line[gi*32 +: 32];
      end
   endgenerate

   // Store hits merge and mark dirty; a refill installs a clean line.
   // The request is held while stalled, so req_idx/req_tag still name the
   // missing line when the ack arrives.
   assign wr_en   = ((state_q == ST_IDLE) & req & hit & cpu_memwr_i) |
                    ((state_q == ST_ALLOCATE) & mem_ack_i);
   assign wr_line = (state_q == ST_ALLOCATE) ? mem_rdata_i : merged_line;

   dcache_sram u_sram (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rd_idx_i   (req_idx),
      .rd_valid_o (rd_valid),
      .rd_dirty_o (rd_dirty),
      .rd_tag_o   (rd_tag),
      .rd_line_o  (rd_line),
      .wr_en_i    (wr_en),
      .wr_idx_i   (req_idx),
      .wr_line_i  (wr_line),
      .wr_tag_i   (req_tag),
      .wr_valid_i (1'b1),
      .wr_dirty_i (state_q == ST_IDLE)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (req && !hit)
                          state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
         ST_WRITEBACK: if (mem_ack_i) state_d = ST_ALLOCATE;
         ST_ALLOCATE:  if (mem_ack_i) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Outputs are decoded from the state and the (combinational) array read.
   // In WRITEBACK the indexed entry is still the victim, so its tag forms the
   // write-back address.
   always_comb begin
      cpu_stall_o  = 1'b0;
      cpu_rdata_o  = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      unique case (state_q)
         ST_IDLE: begin
            cpu_stall_o = req & ~hit;
            if (cpu_memrd_i && hit) cpu_rdata_o = line_words[word_sel];
         end
         ST_WRITEBACK: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {rd_tag, req_idx, {OFFSET_W{1'b0}}};
            mem_wdata_o  = rd_line;
         end
         ST_ALLOCATE: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            mem_addr_o   = {req_tag, req_idx, {OFFSET_W{1'b0}}};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder
//   Directed scenarios followed by a random load/store stream. The bench
//   plays both the pipeline and the backing memory; a flat word-addressed
//   memory model supplies every expected load value.
module tb_dcache_responder;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_wdata_i;
   logic         cpu_memrd_i;
   logic         cpu_memwr_i;
   logic [31:0]  cpu_rdata_o;
   logic         cpu_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o;
   logic [255:0] mem_rdata_i;
   logic         mem_ack_i;

   always #5 clk_i = ~clk_i;

   dcache_responder dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_wdata_i  (cpu_wdata_i),
      .cpu_memrd_i  (cpu_memrd_i),
      .cpu_memwr_i  (cpu_memwr_i),
      .cpu_rdata_o  (cpu_rdata_o),
      .cpu_stall_o  (cpu_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_ack_i    (mem_ack_i)
   );

   int checks = 0;
   int passes = 0;
   int txn    = 0;

   // CPU-visible memory (what loads must return) and the backing memory.
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] bmem    [int unsigned];

   // Results of the last transaction.
   int           t_lat, t_wb_cycles, t_alloc_cycles;
   bit           t_first_stall, t_timeout;
   logic [31:0]  t_wb_addr, t_alloc_addr, t_rdata;
   logic [255:0] t_wb_line;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      int unsigned k = {a[31:2], 2'b00};
      return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
   endfunction

   function automatic logic [255:0] fetch_line(input logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) begin
         int unsigned k = {la[31:5], 5'b0} + 4 * w;
         l[w*32 +: 32] = bmem.exists(k) ? bmem[k] : init_word(k);
      end
      return l;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One request held until served, acting as backing memory meanwhile.
   // fixed_delay = cycles from enable to ack inclusive; 0 = random 1..20.
   task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input int fixed_delay);
      int pc = 0;
      int d  = 1;
      bit done = 0;
      t_lat = 0; t_wb_cycles = 0; t_alloc_cycles = 0; t_first_stall = 0;
      t_timeout = 0; t_wb_addr = '0; t_alloc_addr = '0; t_rdata = '0; t_wb_line = '0;
      @(negedge clk_i);
      cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_memrd_i = rd; cpu_memwr_i = wr;
      while (!done) begin
         #1;
         t_lat++;
         if (t_lat == 1) t_first_stall = cpu_stall_o;
         if (!cpu_stall_o) begin
            t_rdata = cpu_rdata_o;
            done = 1;
         end else if (t_lat > 200) begin
            t_timeout = 1;
            done = 1;
         end else if (mem_enable_o) begin
            if (pc == 0) d = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 20));
            pc++;
            if (mem_write_o) begin
               t_wb_cycles++; t_wb_addr = mem_addr_o; t_wb_line = mem_wdata_o;
            end else begin
               t_alloc_cycles++; t_alloc_addr = mem_addr_o;
            end
            if (pc == d) begin
               mem_ack_i = 1'b1;
               if (mem_write_o) begin
                  for (int w = 0; w < 8; w++)
                     bmem[mem_addr_o + 4 * w] = mem_wdata_o[w*32 +: 32];
               end else begin
                  mem_rdata_i = fetch_line(mem_addr_o);
               end
               pc = 0;
            end
         end
         if (!done) begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
         end
      end
      @(posedge clk_i);
      #1;
      cpu_memrd_i = 1'b0; cpu_memwr_i = 1'b0;
      txn++;
      $display("txn %0d %s addr=%h data=%h lat=%0d wb=%0d alloc=%0d", txn,
               wr ? "ST" : "LD", addr, wr ? wdata : t_rdata, t_lat, t_wb_cycles, t_alloc_cycles);
      check("no_timeout", 256'(t_timeout), 256'(0));
   endtask

   task automatic do_load(input logic [31:0] addr, input int dly);
      logic [31:0] exp = ref_read(addr);
      access(1'b0, 1'b1, addr, 32'h0, dly);
      check("load_data", 256'(t_rdata), 256'(exp));
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                           input int dly, input bit also_rd);
      access(1'b1, also_rd, addr, data, dly);
      ref_mem[{addr[31:2], 2'b00}] = data;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          kind;

      rst_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_memrd_i = 1'b0;
      cpu_memwr_i = 1'b0; mem_rdata_i = '0; mem_ack_i = 1'b0;

      // Reset state
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_stall",  256'(cpu_stall_o),  256'(0));
      check("rst_enable", 256'(mem_enable_o), 256'(0));
      check("rst_write",  256'(mem_write_o),  256'(0));
      check("rst_addr",   256'(mem_addr_o),   256'(0));
      check("rst_wdata",  mem_wdata_o,        256'(0));
      check("rst_rdata",  256'(cpu_rdata_o),  256'(0));
      @(negedge clk_i);
      rst_i = 1'b1;

      // 1: cold load, ack after 10 cycles, then a hit
      bmem[32'h40]    = 32'hDEAD_BEEF;
      ref_mem[32'h40] = 32'hDEAD_BEEF;
      do_load(32'h40, 10);
      check("t1_first_stall", 256'(t_first_stall),  256'(1));
      check("t1_alloc_addr",  256'(t_alloc_addr),   256'(32'h40));
      check("t1_wb_cycles",   256'(t_wb_cycles),    256'(0));
      check("t1_alloc_cycles",256'(t_alloc_cycles), 256'(10));
      check("t1_latency",     256'(t_lat),          256'(1 + 10 + 1));
      check("t1_rdata",       256'(t_rdata),        256'(32'hDEAD_BEEF));
      do_load(32'h40, 10);
      check("t1_hit_latency", 256'(t_lat),          256'(1));
      check("t1_hit_nomem",   256'(t_alloc_cycles), 256'(0));

      // 2: store hit then load back
      do_store(32'h44, 32'h1234_5678, 5, 1'b0);
      check("t2_store_latency", 256'(t_lat), 256'(1));
      do_load(32'h44, 5);
      check("t2_load_latency",  256'(t_lat),   256'(1));
      check("t2_rdata",         256'(t_rdata), 256'(32'h1234_5678));

      // 3: conflict miss on a dirty line -> write-back then allocate
      do_load(32'h440, 5);
      check("t3_wb_addr",    256'(t_wb_addr),        256'(32'h40));
      check("t3_wb_word1",   256'(t_wb_line[63:32]), 256'(32'h1234_5678));
      check("t3_wb_word0",   256'(t_wb_line[31:0]),  256'(32'hDEAD_BEEF));
      check("t3_alloc_addr", 256'(t_alloc_addr),     256'(32'h440));
      check("t3_latency",    256'(t_lat),            256'(1 + 5 + 5 + 1));

      // 4: store miss to a clean line, then evict it
      do_store(32'h88, 32'hCAFE_F00D, 4, 1'b0);
      check("t4_wb_cycles",  256'(t_wb_cycles),  256'(0));
      check("t4_alloc_addr", 256'(t_alloc_addr), 256'(32'h80));
      check("t4_latency",    256'(t_lat),        256'(1 + 4 + 1));
      do_load(32'h88, 4);
      check("t4_hit_latency", 256'(t_lat), 256'(1));
      do_load(32'h488, 3);
      check("t4_wb_addr",  256'(t_wb_addr),         256'(32'h80));
      check("t4_wb_word2", 256'(t_wb_line[95:64]),  256'(32'hCAFE_F00D));
      check("t4_latency2", 256'(t_lat),             256'(1 + 3 + 3 + 1));

      // 5: reset in the middle of ALLOCATE, late ack afterwards
      @(negedge clk_i);
      cpu_addr_i = 32'h40; cpu_memrd_i = 1'b1;
      #1;
      check("t5_miss_stall", 256'(cpu_stall_o), 256'(1));
      repeat (3) @(negedge clk_i);
      #1;
      check("t5_alloc_enable", 256'(mem_enable_o), 256'(1));
      check("t5_alloc_write",  256'(mem_write_o),  256'(0));
      check("t5_alloc_addr",   256'(mem_addr_o),   256'(32'h40));
      @(negedge clk_i);
      rst_i = 1'b0; cpu_memrd_i = 1'b0;
      #1;
      check("t5_rst_enable", 256'(mem_enable_o), 256'(0));
      check("t5_rst_stall",  256'(cpu_stall_o),  256'(0));
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      mem_rdata_i = fetch_line(32'h40);
      mem_ack_i   = 1'b1;
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
      check("t5_late_ack_enable", 256'(mem_enable_o), 256'(0));
      check("t5_late_ack_stall",  256'(cpu_stall_o),  256'(0));
      do_load(32'h40, 3);
      check("t5_reload_miss",  256'(t_first_stall), 256'(1));
      check("t5_reload_addr",  256'(t_alloc_addr),  256'(32'h40));
      check("t5_reload_rdata", 256'(t_rdata),       256'(32'hDEAD_BEEF));

      // 6: random stream over a few tags/indices to force hits and conflicts
      for (int i = 0; i < 300; i++) begin
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
             (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         kind = int'($urandom_range(0, 9));
         if (kind < 5) do_load(a, 0);
         else          do_store(a, $urandom, 0, kind == 9);
         if (t_alloc_cycles > 0)
            check("rand_alloc_addr", 256'(t_alloc_addr), 256'({a[31:5], 5'b0}));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
